// File: rtl/cond_check.sv
// ============================================================================
// Module   : cond_check
// Purpose  : ARM-style condition-code evaluation against NZCV flags, with a
//            combinational execute-enable and a one-cycle registered copy.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cond_check (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx,
    output logic       CondEx_q
);

    localparam logic [3:0] c_EQ = 4'b0000;
    localparam logic [3:0] c_NE = 4'b0001;
    localparam logic [3:0] c_CS = 4'b0010;
    localparam logic [3:0] c_CC = 4'b0011;
    localparam logic [3:0] c_MI = 4'b0100;
    localparam logic [3:0] c_PL = 4'b0101;
    localparam logic [3:0] c_VS = 4'b0110;
    localparam logic [3:0] c_VC = 4'b0111;
    localparam logic [3:0] c_HI = 4'b1000;
    localparam logic [3:0] c_LS = 4'b1001;
    localparam logic [3:0] c_GE = 4'b1010;
    localparam logic [3:0] c_LT = 4'b1011;
    localparam logic [3:0] c_GT = 4'b1100;
    localparam logic [3:0] c_LE = 4'b1101;
    localparam logic [3:0] c_AL = 4'b1110;

    logic w_n;
    logic w_z;
    logic w_c;
    logic w_v;
    logic w_ge;
    logic w_condex;
    logic r_condex_q;

    assign w_n  = Flags[3];
    assign w_z  = Flags[2];
    assign w_c  = Flags[1];
    assign w_v  = Flags[0];
    assign w_ge = ~(w_n ^ w_v);

    // The default arm covers AL and the unconditional space, so every code is defined.
    always_comb begin
        w_condex = 1'b1;
        case (Cond)
            c_EQ:    w_condex = w_z;
            c_NE:    w_condex = ~w_z;
            c_CS:    w_condex = w_c;
            c_CC:    w_condex = ~w_c;
            c_MI:    w_condex = w_n;
            c_PL:    w_condex = ~w_n;
            c_VS:    w_condex = w_v;
            c_VC:    w_condex = ~w_v;
            c_HI:    w_condex = w_c & ~w_z;
            c_LS:    w_condex = ~w_c | w_z;
            c_GE:    w_condex = w_ge;
            c_LT:    w_condex = ~w_ge;
            c_GT:    w_condex = ~w_z & w_ge;
            c_LE:    w_condex = w_z | ~w_ge;
            c_AL:    w_condex = 1'b1;
            default: w_condex = 1'b1;
        endcase
    end

    assign CondEx = w_condex;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_condex_q <= 1'b0;
        end else begin
            r_condex_q <= w_condex;
        end
    end

    assign CondEx_q = r_condex_q;

endmodule

`default_nettype wire

// File: tb/tb_cond_check.sv
// ============================================================================
// Module   : tb_cond_check
// Purpose  : Self-checking bench for cond_check against a pair-based model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cond_check;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] Flags;
    logic       CondEx;
    logic       CondEx_q;

    int vectors;
    int miscompares;

    cond_check u_dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .Flags    (Flags),
        .CondEx   (CondEx),
        .CondEx_q (CondEx_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Each even/odd code pair shares one base predicate; the odd code negates it.
    function automatic logic model(input logic [3:0] c, input logic [3:0] f);
        logic       n, z, cy, v;
        logic [7:0] base;
        int         idx;
        n  = f[3];
        z  = f[2];
        cy = f[1];
        v  = f[0];
        base[0] = z;
        base[1] = cy;
        base[2] = n;
        base[3] = v;
        base[4] = cy && !z;
        base[5] = (n == v);
        base[6] = !z && (n == v);
        base[7] = 1'b1;
        idx = int'(c) / 2;
        if (idx == 7) return 1'b1;
        return base[idx] ^ c[0];
    endfunction

    task automatic test_reset();
        reset = 1'b0;
        Cond  = 4'b1110;
        Flags = 4'($urandom_range(0, 15));
        repeat (2) @(posedge clk);
        #1;
        vectors++;
        if (CondEx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_condex: got %b expected 1", CondEx);
        end
        vectors++;
        if (CondEx_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_q_held: got %b expected 0", CondEx_q);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if (CondEx_q !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release_q: got %b expected 0 before edge", CondEx_q);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (CondEx_q !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_edge_q: got %b expected 1", CondEx_q);
        end
    endtask

    task automatic drive_pipelined(input logic [3:0] c, input logic [3:0] f,
                                   input string tag, inout logic prev_exp);
        logic exp;
        @(posedge clk);
        #1;
        vectors++;
        if (CondEx_q !== prev_exp) begin
            miscompares++;
            $display("FAIL %s_q: got %b expected %b", tag, CondEx_q, prev_exp);
        end
        Cond  = c;
        Flags = f;
        exp   = model(c, f);
        #1;
        vectors++;
        if (CondEx !== exp) begin
            miscompares++;
            $display("FAIL %s_comb cond=%b flags=%b: got %b expected %b", tag, c, f, CondEx, exp);
        end
        prev_exp = exp;
    endtask

    task automatic test_sweep();
        logic prev;
        Cond  = 4'b0000;
        Flags = 4'b0100;
        #1;
        prev = model(Cond, Flags);
        vectors++;
        if (CondEx !== 1'b1) begin
            miscompares++;
            $display("FAIL sweep_eq_z: got %b expected 1", CondEx);
        end
        for (int i = 0; i < 16; i++) begin
            drive_pipelined(4'(i), 4'($urandom_range(0, 15)), "sweep", prev);
        end
        drive_pipelined(4'b1000, 4'b0110, "sweep_hi_z", prev);
        vectors++;
        if (CondEx !== 1'b0) begin
            miscompares++;
            $display("FAIL sweep_hi_zset: got %b expected 0", CondEx);
        end
        drive_pipelined(4'b1110, 4'b0000, "sweep_tail", prev);
    endtask

    task automatic test_exhaustive();
        logic a, b;
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c += 2) begin
                Cond  = 4'(c);
                Flags = 4'(f);
                #1;
                a = CondEx;
                vectors++;
                if (a !== model(4'(c), 4'(f))) begin
                    miscompares++;
                    $display("FAIL exh cond=%0d flags=%0d: got %b expected %b", c, f, a, model(4'(c), 4'(f)));
                end
                Cond = 4'(c + 1);
                #1;
                b = CondEx;
                vectors++;
                if (b !== model(4'(c + 1), 4'(f))) begin
                    miscompares++;
                    $display("FAIL exh cond=%0d flags=%0d: got %b expected %b", c + 1, f, b, model(4'(c + 1), 4'(f)));
                end
                if (c < 14) begin
                    vectors++;
                    if (b !== ~a) begin
                        miscompares++;
                        $display("FAIL complement cond=%0d flags=%0d: got %b/%b expected complements", c, f, a, b);
                    end
                end
            end
        end
    endtask

    task automatic test_corners();
        logic [3:0] cs [9] = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1001, 4'b1001, 4'b1100, 4'b0000, 4'b1000};
        logic [3:0] fs [9] = '{4'b1001, 4'b1000, 4'b0000, 4'b0001, 4'b0000, 4'b0010, 4'b1100, 4'b0100, 4'b0110};
        logic       ex [9] = '{1'b1,    1'b1,    1'b1,    1'b1,    1'b1,    1'b0,    1'b0,    1'b1,    1'b0};
        for (int i = 0; i < 9; i++) begin
            Cond  = cs[i];
            Flags = fs[i];
            #1;
            vectors++;
            if (CondEx !== ex[i]) begin
                miscompares++;
                $display("FAIL corner cond=%b flags=%b: got %b expected %b", cs[i], fs[i], CondEx, ex[i]);
            end
        end
    endtask

    task automatic test_always_true();
        for (int c = 14; c < 16; c++) begin
            for (int f = 0; f < 16; f++) begin
                Cond  = 4'(c);
                Flags = 4'(f);
                #1;
                vectors++;
                if (CondEx !== 1'b1) begin
                    miscompares++;
                    $display("FAIL always_true cond=%0d flags=%0d: got %b expected 1", c, f, CondEx);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        logic prev;
        prev = model(Cond, Flags);
        drive_pipelined(4'b1110, 4'($urandom_range(0, 15)), "async_pre", prev);
        @(posedge clk);
        #1;
        vectors++;
        if (CondEx_q !== 1'b1) begin
            miscompares++;
            $display("FAIL async_q_before: got %b expected 1", CondEx_q);
        end
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (CondEx_q !== 1'b0) begin
            miscompares++;
            $display("FAIL async_q_drop: got %b expected 0", CondEx_q);
        end
        vectors++;
        if (CondEx !== 1'b1) begin
            miscompares++;
            $display("FAIL async_condex: got %b expected 1", CondEx);
        end
        Flags = 4'b0100;
        Cond  = 4'b0001;
        #1;
        vectors++;
        if (CondEx !== 1'b0) begin
            miscompares++;
            $display("FAIL async_track: got %b expected 0", CondEx);
        end
        Cond = 4'b1110;
        @(posedge clk);
        #1;
        vectors++;
        if (CondEx_q !== 1'b0) begin
            miscompares++;
            $display("FAIL async_held: got %b expected 0", CondEx_q);
        end
        #1 reset = 1'b1;
        @(posedge clk);
        #1;
        vectors++;
        if (CondEx_q !== 1'b1) begin
            miscompares++;
            $display("FAIL async_release: got %b expected 1", CondEx_q);
        end
    endtask

    task automatic test_back_to_back();
        logic prev;
        prev = model(Cond, Flags);
        for (int i = 0; i < 200; i++) begin
            drive_pipelined(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), "b2b", prev);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        Cond        = 4'b0000;
        Flags       = 4'b0000;
        test_reset();
        test_sweep();
        test_exhaustive();
        test_corners();
        test_always_true();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
